window_gen_param: RTL and testbench

//  Parametrised successor of the fixed 3x3 window generator in the median-filter datapath.
//  - Accepts WIN rows of LANE pixels in one valid/ready beat.
//  - Emits every WIN x WIN window across that row segment, one per accepted output beat.
//  - Optional border padding. Sits between the APB/memory row fetcher and the median sorter.
//  - Replaces flag/edge handshakes with valid/ready on both sides.

---
 rtl/medfilt_pkg.sv | 21 ++
 rtl/win_col_sel.sv | 44 ++++
 rtl/window_gen_param.sv | 104 ++++++++++
 tb/tb_window_gen_param.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/medfilt_pkg.sv
// rtl/medfilt_pkg.sv - shared median-filter constants, FSM state type and window-count helper
// Purpose: padding-mode constants and the window-count function used by the window
//          generator and the median sorter, plus the window generator state type.
// Ports:   none (package).
package medfilt_pkg;

    localparam int PAD_NONE = 0;
    localparam int PAD_ZERO = 1;
    localparam int PAD_REPL = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } win_state_t;

    // Number of window positions produced from one row beat.
    function automatic int npos(input int win, input int lane, input int pad_mode);
        return (pad_mode == PAD_NONE) ? (lane - win + 1) : lane;
    endfunction

endpackage

// File: rtl/win_col_sel.sv
// rtl/win_col_sel.sv - selects one (optionally padded) pixel of a buffered row for a window column
// Purpose: for window position pos_i and fixed element column C, return the source pixel
//          of one buffered row, applying zero or edge-replicate padding when out of range.
// Ports:   row_i  - LANE pixels of one buffered row, pixel i at [i*PIX_W +: PIX_W]
//          pos_i  - current window position
//          pix_o  - selected pixel
module win_col_sel
    import medfilt_pkg::*;
#(
    parameter int PIX_W    = 16,
    parameter int WIN      = 3,
    parameter int LANE     = 4,
    parameter int PAD_MODE = PAD_NONE,
    parameter int C        = 0
) (
    input  logic [LANE*PIX_W-1:0]    row_i,
    input  logic [$clog2(LANE)-1:0]  pos_i,
    output logic [PIX_W-1:0]         pix_o
);

    // Padded modes centre the window on pos, so the leftmost column looks H pixels back.
    localparam int OFF = (PAD_MODE == PAD_NONE) ? 0 : (WIN - 1) / 2;

    int src;

    always_comb begin
        pix_o = '0;
        src   = int'(pos_i) + C - OFF;
        if (PAD_MODE == PAD_REPL) begin
            if (src < 0) begin
                src = 0;
            end else if (src > LANE - 1) begin
                src = LANE - 1;
            end
        end
        // An out-of-range source matches no lane and leaves the zero default (zero padding).
        for (int i = 0; i < LANE; i++) begin
            if (src == i) begin
                pix_o = row_i[i*PIX_W +: PIX_W];
            end
        end
    end

endmodule

// File: rtl/window_gen_param.sv
// rtl/window_gen_param.sv - parametrised WIN x WIN window generator with valid/ready on both sides
// Purpose: accepts WIN rows of LANE pixels per beat and emits every WIN x WIN window across
//          the row segment, one window per accepted output beat, with optional border padding.
// Ports:   clk, rst                      - clock, asynchronous active-high reset
//          in_valid/in_ready/in_data     - row beat input, row r pixel i at [(r*LANE+i)*PIX_W]
//          win_valid/win_ready/win_data  - window output, element (r,c) at [(r*WIN+c)*PIX_W]
//          win_pos                       - window index within the current beat
//          win_last                      - final window of the current beat
module window_gen_param
    import medfilt_pkg::*;
#(
    parameter int PIX_W    = 16,
    parameter int WIN      = 3,
    parameter int LANE     = 4,
    parameter int PAD_MODE = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIN*LANE*PIX_W-1:0]   in_data,
    output logic                        win_valid,
    input  logic                        win_ready,
    output logic [WIN*WIN*PIX_W-1:0]    win_data,
    output logic [$clog2(LANE)-1:0]     win_pos,
    output logic                        win_last
);

    localparam int PW   = $clog2(LANE);
    localparam int NPOS = npos(WIN, LANE, PAD_MODE);

    if ((WIN % 2) == 0 || WIN < 3) begin : g_bad_win
        $error("window_gen_param: WIN must be odd and >= 3");
    end
    if (PAD_MODE == PAD_NONE && LANE < WIN) begin : g_bad_lane
        $error("window_gen_param: LANE must be >= WIN without padding");
    end
    if (PAD_MODE < 0 || PAD_MODE > 2) begin : g_bad_pad
        $error("window_gen_param: PAD_MODE must be 0, 1 or 2");
    end

    win_state_t                 state_q, state_d;
    logic [PW-1:0]              pos_q, pos_d;
    logic [WIN*LANE*PIX_W-1:0]  buf_q, buf_d;

    logic out_take;
    logic last_take;
    logic load;

    always_comb begin
        win_valid = (state_q == ST_EMIT);
        win_pos   = pos_q;
        win_last  = (state_q == ST_EMIT) && (pos_q == PW'(NPOS - 1));
        out_take  = win_valid && win_ready;
        last_take = out_take && win_last;
        // Ready on the final accepted window as well as in IDLE, so the next beat
        // loads with no bubble.
        in_ready  = !rst && ((state_q == ST_IDLE) || last_take);
        load      = in_valid && in_ready;

        state_d = state_q;
        pos_d   = pos_q;
        buf_d   = buf_q;
        if (load) begin
            buf_d   = in_data;
            pos_d   = '0;
            state_d = ST_EMIT;
        end else if (last_take) begin
            pos_d   = '0;
            state_d = ST_IDLE;
        end else if (out_take) begin
            pos_d   = pos_q + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pos_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            buf_q   <= buf_d;
        end
    end

    for (genvar r = 0; r < WIN; r++) begin : g_row
        for (genvar c = 0; c < WIN; c++) begin : g_col
            win_col_sel #(
                .PIX_W    (PIX_W),
                .WIN      (WIN),
                .LANE     (LANE),
                .PAD_MODE (PAD_MODE),
                .C        (c)
            ) u_sel (
                .row_i (buf_q[r*LANE*PIX_W +: LANE*PIX_W]),
                .pos_i (pos_q),
                .pix_o (win_data[(r*WIN+c)*PIX_W +: PIX_W])
            );
        end
    end

endmodule

// File: tb/tb_window_gen_param.sv
// tb/tb_window_gen_param.sv - self-checking bench for window_gen_param in all three padding modes
module tb_window_gen_param;

    localparam int DW = 3 * 4 * 16;
    localparam int OW = 3 * 3 * 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]    in_valid;
    logic [2:0]    in_ready;
    logic [2:0]    win_valid;
    logic [2:0]    win_ready;
    logic [2:0]    win_last;
    logic [DW-1:0] in_data  [3];
    logic [OW-1:0] win_data [3];
    logic [1:0]    win_pos  [3];

    int checks = 0;
    int errors = 0;

    logic [OW-1:0] cap [3][4];

    // Instance g is built with PAD_MODE = g: 0 none, 1 zero, 2 replicate.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        window_gen_param #(
            .PIX_W    (16),
            .WIN      (3),
            .LANE     (4),
            .PAD_MODE (g)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_data   (in_data[g]),
            .win_valid (win_valid[g]),
            .win_ready (win_ready[g]),
            .win_data  (win_data[g]),
            .win_pos   (win_pos[g]),
            .win_last  (win_last[g])
        );
    end

    task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int np_of(input int mode);
        return (mode == 0) ? 2 : 4;
    endfunction

    // Reference window: source column p+c (no padding) or p+c-1 with zero/clamp at the edges.
    function automatic logic [OW-1:0] ref_win(input logic [DW-1:0] beat, input int mode, input int p);
        logic [OW-1:0] w;
        int s;
        w = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                s = (mode == 0) ? (p + c) : (p + c - 1);
                if (s < 0 || s > 3) begin
                    if (mode == 2) s = (s < 0) ? 0 : 3;
                    else           s = -1;
                end
                if (s >= 0) w[(r*3+c)*16 +: 16] = beat[(r*4+s)*16 +: 16];
            end
        end
        return w;
    endfunction

    function automatic logic [15:0] el(input logic [OW-1:0] w, input int r, input int c);
        return w[(r*3+c)*16 +: 16];
    endfunction

    task automatic load(input int d, input logic [DW-1:0] beat);
        @(negedge clk);
        in_valid[d] = 1'b1;
        in_data[d]  = beat;
        #1;
        chk("load_in_ready", in_ready[d], 1'b1);
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
    endtask

    task automatic emit(input int d, input logic [DW-1:0] beat, input int stall_first, input int stall_pct);
        int p;
        int np;
        p  = 0;
        np = np_of(d);
        for (int cyc = 0; cyc < 100 && p < np; cyc++) begin
            @(negedge clk);
            win_ready[d] = (cyc >= stall_first) && ($urandom_range(99) >= stall_pct);
            #1;
            chk("win_valid", win_valid[d], 1'b1);
            chk("win_pos", win_pos[d], p[1:0]);
            chk("win_data", win_data[d], ref_win(beat, d, p));
            chk("win_last", win_last[d], p == np - 1);
            chk("in_ready_emit", in_ready[d], win_ready[d] && (p == np - 1));
            cap[d][p] = win_data[d];
            @(posedge clk);
            if (win_ready[d]) p++;
        end
        chk("emit_done", p, np);
    endtask

    task automatic idle_chk(input int d);
        @(negedge clk);
        win_ready[d] = 1'b0;
        #1;
        chk("idle_valid", win_valid[d], 1'b0);
        chk("idle_in_ready", in_ready[d], 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] base;
        logic [DW-1:0] bb;
        logic [DW-1:0] rnd;

        for (int r = 0; r < 3; r++)
            for (int i = 0; i < 4; i++)
                base[(r*4+i)*16 +: 16] = 16'(16 * r + i);
        for (int i = 0; i < 12; i++) bb[i*16 +: 16] = 16'hAAAA;

        in_valid  = '0;
        win_ready = '0;
        for (int d = 0; d < 3; d++) in_data[d] = '0;

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("rst_win_valid", win_valid[d], 1'b0);
            chk("rst_win_data", win_data[d], '0);
            chk("rst_win_pos", win_pos[d], 2'd0);
            chk("rst_win_last", win_last[d], 1'b0);
            chk("rst_in_ready", in_ready[d], 1'b0);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) chk("rel_in_ready", in_ready[d], 1'b1);

        // T1 / T3 / T4: base beat, no stalls, every mode
        for (int d = 0; d < 3; d++) begin
            load(d, base);
            emit(d, base, 0, 0);
            idle_chk(d);
        end
        chk("t1_pos0", cap[0][0], {16'h22, 16'h21, 16'h20, 16'h12, 16'h11, 16'h10, 16'h02, 16'h01, 16'h00});
        chk("t1_pos1", cap[0][1], {16'h23, 16'h22, 16'h21, 16'h13, 16'h12, 16'h11, 16'h03, 16'h02, 16'h01});
        chk("t3_p0_col0", {el(cap[1][0], 0, 0), el(cap[1][0], 1, 0), el(cap[1][0], 2, 0)}, 48'h0);
        chk("t3_p0_col1", {el(cap[1][0], 0, 1), el(cap[1][0], 1, 1), el(cap[1][0], 2, 1)},
            {16'h0000, 16'h0010, 16'h0020});
        chk("t3_p3_col2", {el(cap[1][3], 0, 2), el(cap[1][3], 1, 2), el(cap[1][3], 2, 2)}, 48'h0);
        chk("t4_p0_row1", {el(cap[2][0], 1, 0), el(cap[2][0], 1, 1), el(cap[2][0], 1, 2)},
            {16'h0010, 16'h0010, 16'h0011});
        chk("t4_p3_row2", {el(cap[2][3], 2, 0), el(cap[2][3], 2, 1), el(cap[2][3], 2, 2)},
            {16'h0022, 16'h0023, 16'h0023});

        // T2: stall 3 cycles at pos0
        load(0, base);
        emit(0, base, 3, 0);
        idle_chk(0);

        // T5: back-to-back, second beat held valid throughout the first
        load(0, base);
        in_valid[0] = 1'b1;
        in_data[0]  = bb;
        @(negedge clk);
        win_ready[0] = 1'b1;
        #1;
        chk("t5_pos0", win_pos[0], 2'd0);
        chk("t5_data0", win_data[0], ref_win(base, 0, 0));
        chk("t5_in_ready0", in_ready[0], 1'b0);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("t5_pos1", win_pos[0], 2'd1);
        chk("t5_last1", win_last[0], 1'b1);
        chk("t5_data1", win_data[0], ref_win(base, 0, 1));
        chk("t5_in_ready1", in_ready[0], 1'b1);
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        chk("t5_nogap_valid", win_valid[0], 1'b1);
        chk("t5_nogap_pos", win_pos[0], 2'd0);
        chk("t5_nogap_data", win_data[0], {9{16'hAAAA}});
        emit(0, bb, 0, 0);
        idle_chk(0);

        // Randomised beats with random output stalls
        for (int d = 0; d < 3; d++) begin
            for (int k = 0; k < 5; k++) begin
                for (int j = 0; j < 6; j++) rnd[j*32 +: 32] = $urandom;
                load(d, rnd);
                emit(d, rnd, 0, 30);
                idle_chk(d);
            end
        end

        // T6: asynchronous reset during EMIT at pos1
        load(0, base);
        @(negedge clk);
        win_ready[0] = 1'b1;
        #1;
        chk("t6_pos0", win_pos[0], 2'd0);
        @(posedge clk);
        @(negedge clk);
        win_ready[0] = 1'b0;
        #1;
        chk("t6_pos1", win_pos[0], 2'd1);
        chk("t6_valid_pre", win_valid[0], 1'b1);
        #1;
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", win_valid[0], 1'b0);
        chk("t6_rst_data", win_data[0], '0);
        chk("t6_rst_pos", win_pos[0], 2'd0);
        chk("t6_rst_in_ready", in_ready[0], 1'b0);
        @(posedge clk);
        #1;
        chk("t6_rst_in_ready_hold", in_ready[0], 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t6_rel_in_ready", in_ready[0], 1'b1);
        chk("t6_rel_valid", win_valid[0], 1'b0);
        load(0, base);
        emit(0, base, 0, 0);
        idle_chk(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
